// File: rtl/data_sel_scan_if.sv
// Control, data and result signals of the registered N-channel selector.
// The controller side drives selection/data; the selector returns q/ch/ch_stb.
interface data_sel_scan_if #(
  parameter int WIDTH = 4,
  parameter int NCH   = 4,
  parameter int SELW  = 2
);
  logic                   mode;
  logic [SELW-1:0]        sel;
  logic                   hold;
  logic [NCH*WIDTH-1:0]   d;
  logic [WIDTH-1:0]       q;
  logic [SELW-1:0]        ch;
  logic                   ch_stb;

  modport master (
    output mode, sel, hold, d,
    input  q, ch, ch_stb
  );

  modport slave (
    input  mode, sel, hold, d,
    output q, ch, ch_stb
  );
endinterface

// File: rtl/data_sel_scan.sv
// Registered N-channel data selector with manual select and round-robin scan.
// q, ch and ch_stb are all registered and always describe the same channel.
module data_sel_scan #(
  parameter int WIDTH = 4,
  parameter int NCH   = 4,
  parameter int SELW  = 2,
  parameter int DWELL = 16
) (
  input  logic               clk,
  input  logic               reset,
  data_sel_scan_if.slave     bus
);

  localparam int              CNTW     = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(DWELL - 1);
  localparam logic [SELW-1:0] CH_LAST  = SELW'(NCH - 1);
  localparam logic [SELW:0]   NCH_W    = (SELW + 1)'(NCH);

  typedef enum logic {
    MANUAL,
    SCAN
  } state_t;

  state_t          state;
  logic [CNTW-1:0] cnt;
  logic [CNTW-1:0] cnt_next;
  logic [SELW-1:0] ch_r;
  logic [SELW-1:0] ch_next;
  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] q_next;
  logic            stb_r;

  // cnt is forced to 0 throughout MANUAL (even under hold), so every
  // entry into SCAN starts a full dwell from the current channel.
  always_comb begin
    ch_next  = ch_r;
    cnt_next = cnt;
    if (state == MANUAL) begin
      cnt_next = '0;
      if (!bus.hold && ({1'b0, bus.sel} < NCH_W)) begin
        ch_next = bus.sel;
      end
    end else if (!bus.hold) begin
      if (cnt == CNT_LAST) begin
        cnt_next = '0;
        ch_next  = (ch_r == CH_LAST) ? '0 : ch_r + 1'b1;
      end else begin
        cnt_next = cnt + 1'b1;
      end
    end
  end

  always_comb begin
    q_next = '0;
    for (int unsigned k = 0; k < NCH; k++) begin
      if (ch_next == SELW'(k)) begin
        q_next = bus.d[k*WIDTH +: WIDTH];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= MANUAL;
      cnt   <= '0;
      ch_r  <= '0;
      q_r   <= '0;
      stb_r <= 1'b0;
    end else begin
      state <= bus.mode ? SCAN : MANUAL;
      cnt   <= cnt_next;
      ch_r  <= ch_next;
      q_r   <= q_next;
      stb_r <= (ch_next != ch_r);
    end
  end

  assign bus.q      = q_r;
  assign bus.ch     = ch_r;
  assign bus.ch_stb = stb_r;

endmodule

// File: tb/tb_data_sel_scan.sv
// Bench for data_sel_scan: two instances (4ch/DWELL=4 and 3ch/DWELL=1) checked
// every cycle against an integer-level model plus hand-computed literal points.
module tb_data_sel_scan;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   vectors = 0;
  int   errors  = 0;

  always #5 clk = ~clk;

  data_sel_scan_if #(.WIDTH(4), .NCH(4), .SELW(2)) ifa ();
  data_sel_scan_if #(.WIDTH(4), .NCH(3), .SELW(2)) ifb ();

  data_sel_scan #(.WIDTH(4), .NCH(4), .SELW(2), .DWELL(4)) dut_a (
    .clk(clk), .reset(reset), .bus(ifa)
  );
  data_sel_scan #(.WIDTH(4), .NCH(3), .SELW(2), .DWELL(1)) dut_b (
    .clk(clk), .reset(reset), .bus(ifb)
  );

  typedef struct {
    int ch;
    int cnt;
    int q;
    bit stb;
    bit scan;
  } mstate_t;

  mstate_t ma = '{default: 0};
  mstate_t mb = '{default: 0};

  // One clock of the selector as described: integers, modulo wrap, shift-and-mask slice.
  function automatic mstate_t step(mstate_t s, int nch, int dwell, int w,
                                   logic mode, int sel, logic hold, logic [31:0] d);
    mstate_t n = s;
    int nxt = s.ch;
    if (!s.scan) n.cnt = 0;
    if (!hold) begin
      if (!s.scan) begin
        if (sel < nch) nxt = sel;
      end else if (s.cnt == dwell - 1) begin
        n.cnt = 0;
        nxt = (s.ch + 1) % nch;
      end else begin
        n.cnt = s.cnt + 1;
      end
    end
    n.stb  = (nxt != s.ch);
    n.ch   = nxt;
    n.q    = int'((d >> (nxt * w)) & ((32'd1 << w) - 1));
    n.scan = mode;
    return n;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      ma <= '{default: 0};
      mb <= '{default: 0};
    end else begin
      ma <= step(ma, 4, 4, 4, ifa.mode, int'(ifa.sel), ifa.hold, 32'(ifa.d));
      mb <= step(mb, 3, 1, 4, ifb.mode, int'(ifb.sel), ifb.hold, 32'(ifb.d));
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always begin
    @(posedge clk);
    #2;
    chk("A.q",   32'(ifa.q),      32'(ma.q));
    chk("A.ch",  32'(ifa.ch),     32'(ma.ch));
    chk("A.stb", 32'(ifa.ch_stb), 32'(ma.stb));
    chk("B.q",   32'(ifb.q),      32'(mb.q));
    chk("B.ch",  32'(ifb.ch),     32'(mb.ch));
    chk("B.stb", 32'(ifb.ch_stb), 32'(mb.stb));
  end

  task automatic edges(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic lit_a(input string tag, input int q, input int ch, input bit stb);
    chk({tag, ".q"},   32'(ifa.q),      32'(q));
    chk({tag, ".ch"},  32'(ifa.ch),     32'(ch));
    chk({tag, ".stb"}, 32'(ifa.ch_stb), 32'(stb));
  endtask

  task automatic lit_b(input string tag, input int q, input int ch, input bit stb);
    chk({tag, ".q"},   32'(ifb.q),      32'(q));
    chk({tag, ".ch"},  32'(ifb.ch),     32'(ch));
    chk({tag, ".stb"}, 32'(ifb.ch_stb), 32'(stb));
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    ifa.mode = 1'b0; ifa.sel = '0; ifa.hold = 1'b0; ifa.d = 16'h4321;
    ifb.mode = 1'b0; ifb.sel = '0; ifb.hold = 1'b0; ifb.d = 12'h321;
    #1 reset = 1'b1;
    edges(2);
    lit_a("rst_a", 0, 0, 1'b0);
    lit_b("rst_b", 0, 0, 1'b0);
    reset = 1'b0;

    // Manual select
    ifa.sel = 2'd2;
    edges(1); lit_a("sel2", 4'h3, 2, 1'b1);
    edges(1); lit_a("sel2_hold", 4'h3, 2, 1'b0);
    ifa.d = 16'h4A21;
    edges(1); lit_a("live_d", 4'hA, 2, 1'b0);
    ifa.sel = 2'd0;
    edges(1); lit_a("sel0", 4'h1, 0, 1'b1);

    // Auto-scan with DWELL=4: first advance 5 edges after mode=1 (one for state)
    ifa.mode = 1'b1;
    edges(5);  lit_a("scan_ch1", 4'h2, 1, 1'b1);
    edges(11); lit_a("scan_ch3", 4'h4, 3, 1'b0);
    edges(1);  lit_a("scan_wrap", 4'h1, 0, 1'b1);

    // Hold at cnt=2, data still tracked, then resume with 2 cycles left
    edges(2);
    ifa.hold = 1'b1;
    ifa.d = 16'h4A25;
    edges(10); lit_a("hold", 4'h5, 0, 1'b0);
    ifa.hold = 1'b0;
    edges(1);  lit_a("rel1", 4'h5, 0, 1'b0);
    edges(1);  lit_a("rel2", 4'h2, 1, 1'b1);
    edges(8);  lit_a("at_ch3", 4'h4, 3, 1'b1);

    // Asynchronous reset between edges, while the strobe is high
    @(posedge clk);
    #3 reset = 1'b1;
    #1 lit_a("async_rst", 0, 0, 1'b0);
    lit_b("async_rst_b", 0, 0, 1'b0);
    ifa.mode = 1'b0;
    ifa.sel  = 2'd1;
    @(negedge clk);
    reset = 1'b0;
    edges(1); lit_a("post_rst", 4'h2, 1, 1'b1);

    // Three channels: out-of-range sel, then DWELL=1 scan with 2->0 wrap
    ifb.sel = 2'd1;
    edges(1); lit_b("b_sel1", 4'h2, 1, 1'b1);
    ifb.sel = 2'd3;
    edges(1); lit_b("b_oor", 4'h2, 1, 1'b0);
    ifb.mode = 1'b1;
    edges(1); lit_b("b_modechg", 4'h2, 1, 1'b0);
    edges(1); lit_b("b_adv", 4'h3, 2, 1'b1);
    edges(1); lit_b("b_wrap", 4'h1, 0, 1'b1);
    edges(1); lit_b("b_adv1", 4'h2, 1, 1'b1);
    ifb.mode = 1'b0;
    ifb.sel  = 2'd0;
    edges(4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
